// File: rtl/gda_ctrl_pkg.sv
// Shared constants and state encoding for the variable-latency GDA adder controller.
package gda_ctrl_pkg;

    localparam int unsigned DefaultN    = 8;
    localparam int unsigned DefaultP    = 6;
    localparam int unsigned DefaultCntW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StCorr = 2'd2,
        StDone = 2'd3
    } gda_state_e;

endpackage

// File: rtl/gda_approx_core.sv
// Combinational GDA-style approximate adder: every carry, including the carry out,
// only sees generate bits inside a window of P positions below it.
module gda_approx_core #(
    parameter int unsigned N = 8,
    parameter int unsigned P = 6
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N:0]   res
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         term;

    assign g = in1 & in2;
    assign p = in1 ^ in2;

    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            for (int j = 0; j < i; j++) begin
                if (j + int'(P) >= i) begin
                    // generate at j survives only if every bit between j and i propagates
                    term = g[j];
                    for (int k = j + 1; k < i; k++) begin
                        term = term & p[k];
                    end
                    c[i] = c[i] | term;
                end
            end
        end
    end

    assign res = {c[N], p ^ c[N-1:0]};

endmodule

// File: rtl/gda_varlat_ctrl.sv
// Variable-latency controller: evaluates the approximate sum, compares it with the exact
// sum and spends one extra cycle on correction unless the request asked for approximation.
module gda_varlat_ctrl
    import gda_ctrl_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned P     = DefaultP,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in1,
    input  logic [N-1:0]     in2,
    input  logic             mode_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N:0]       res,
    output logic             res_err,
    output logic             res_corr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    gda_state_e   state_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         mode_q;

    logic [N:0]   approx;
    logic [N:0]   exact;
    logic         err;

    gda_approx_core #(
        .N (N),
        .P (P)
    ) u_core (
        .in1 (a_q),
        .in2 (b_q),
        .res (approx)
    );

    assign exact = {1'b0, a_q} + {1'b0, b_q};
    assign err   = (approx != exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            res_err   <= 1'b0;
            res_corr  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        mode_q   <= mode_approx;
                        in_ready <= 1'b0;
                        state_q  <= StEval;
                    end
                end
                StEval: begin
                    if (!err || mode_q) begin
                        res       <= approx;
                        res_err   <= err;
                        res_corr  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        res_err  <= 1'b1;
                        res_corr <= 1'b0;
                        state_q  <= StCorr;
                    end
                end
                StCorr: begin
                    res       <= exact;
                    res_corr  <= 1'b1;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (state_q == StEval && err && !(&err_cnt)) begin
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_gda_varlat_ctrl.sv
// Directed bench for gda_varlat_ctrl; a second instance with a 2-bit counter checks saturation.
module tb_gda_varlat_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         mode_approx;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   res;
    logic         res_err;
    logic         res_corr;
    logic         cnt_clr;
    logic [15:0]  err_cnt;

    logic         in_ready2;
    logic         out_valid2;
    logic [N:0]   res2;
    logic         res_err2;
    logic         res_corr2;
    logic [1:0]   err_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gda_varlat_ctrl #(
        .N     (8),
        .P     (6),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .mode_approx (mode_approx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res         (res),
        .res_err     (res_err),
        .res_corr    (res_corr),
        .cnt_clr     (cnt_clr),
        .err_cnt     (err_cnt)
    );

    gda_varlat_ctrl #(
        .N     (8),
        .P     (6),
        .CNT_W (2)
    ) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready2),
        .in1         (in1),
        .in2         (in2),
        .mode_approx (mode_approx),
        .out_valid   (out_valid2),
        .out_ready   (out_ready),
        .res         (res2),
        .res_err     (res_err2),
        .res_corr    (res_corr2),
        .cnt_clr     (cnt_clr),
        .err_cnt     (err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand pair, then scrambles the inputs to show they are ignored.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
        int w;
        w = 0;
        while (!in_ready && w < 10) begin
            tick();
            w++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in1         = a;
        in2         = b;
        mode_approx = m;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        in1         = 8'hA5;
        in2         = 8'h5A;
        mode_approx = ~m;
    endtask

    task automatic wait_out(input string tag, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [N:0] r, input logic e,
                             input logic c);
        check({tag, "_res"}, 32'(res), 32'(r));
        check({tag, "_res_err"}, 32'(res_err), 32'(e));
        check({tag, "_res_corr"}, 32'(res_corr), 32'(c));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in1         = '0;
        in2         = '0;
        mode_approx = 1'b0;
        out_ready   = 1'b0;
        cnt_clr     = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_res_corr", 32'(res_corr), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Exact case
        send(8'h12, 8'h34, 1'b0);
        wait_out("exact", 1, 2);
        check_res("exact", 9'h046, 1'b0, 1'b0);
        release_out("exact");
        check("exact_err_cnt", 32'(err_cnt), 32'd0);

        // Long chain, corrected
        send(8'h7F, 8'h01, 1'b0);
        wait_out("chain", 1, 3);
        check_res("chain", 9'h080, 1'b1, 1'b1);
        release_out("chain");
        check("chain_err_cnt", 32'(err_cnt), 32'd1);

        // Long chain, approximate mode
        send(8'h7F, 8'h01, 1'b1);
        wait_out("approx", 1, 2);
        check_res("approx", 9'h000, 1'b1, 1'b0);
        release_out("approx");
        check("approx_err_cnt", 32'(err_cnt), 32'd2);

        // All-generate: every carry comes from the adjacent bit, so exact
        send(8'hFF, 8'hFF, 1'b0);
        wait_out("ffff", 1, 2);
        check_res("ffff", 9'h1FE, 1'b0, 1'b0);
        release_out("ffff");

        // Carry out lost by the window, corrected
        send(8'hFF, 8'h01, 1'b0);
        wait_out("ff01", 1, 3);
        check_res("ff01", 9'h100, 1'b1, 1'b1);
        release_out("ff01");
        check("ff01_err_cnt", 32'(err_cnt), 32'd3);
        check("ff01_err_cnt_sat", 32'(err_cnt2), 32'd3);

        // Backpressure in DONE
        send(8'h7F, 8'h01, 1'b1);
        wait_out("bp", 1, 2);
        for (int i = 0; i < 5; i++) begin
            in1 = 8'(i * 37);
            tick();
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_res_stable", 32'(res), 32'h000);
            check("bp_res_err_stable", 32'(res_err), 32'd1);
        end
        release_out("bp");
        check("bp_err_cnt", 32'(err_cnt), 32'd4);
        check("bp_err_cnt_sat", 32'(err_cnt2), 32'd3);

        // Approximate result of the window-limited carry out
        send(8'hFF, 8'h01, 1'b1);
        wait_out("ff01a", 1, 2);
        check_res("ff01a", 9'h080, 1'b1, 1'b0);
        release_out("ff01a");
        check("ff01a_err_cnt", 32'(err_cnt), 32'd5);
        check("ff01a_err_cnt_sat", 32'(err_cnt2), 32'd3);

        // Clear coinciding with an erroneous EVAL cycle
        send(8'h7F, 8'h01, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_err_cnt_sat", 32'(err_cnt2), 32'd0);
        wait_out("clr", 2, 3);
        check_res("clr", 9'h080, 1'b1, 1'b1);
        release_out("clr");

        // Reset while in CORR
        send(8'h7F, 8'h01, 1'b0);
        tick();
        check("corr_out_valid_pre", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_res", 32'(res), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
